ham_16_11_dec_pipe: RTL

- Streaming SECDED decoder stage that sits directly downstream of the Hamming (16,11) encoder.
- Accepts 16-bit codewords (layout below) over a valid/ready handshake, computes syndrome and overall parity, corrects single-bit errors, flags double-bit errors, and returns the 11-bit data.
- Two-stage elastic pipeline with full backpressure.
- Saturating SEC/DED event counters and a sticky DED flag for the slow-control register bank.

---
 rtl/ham_pkg.sv | 24 ++
 rtl/ham_16_11_syn.sv | 36 +++
 rtl/ham_16_11_dec_pipe.sv | 110 +++++++++++
 3 files changed

// File: rtl/ham_pkg.sv
// Shared constants and helpers for the Hamming (16,11) SECDED codec family.
// Codeword layout: {P16,D11..D5,P8,D4..D2,P4,D1,P2,P1}, bit0 = P1.
package ham_pkg;

  // Each mask selects the codeword bits covered by one syndrome bit
  localparam logic [15:0] SYN_MASK_S1 = 16'h5555;
  localparam logic [15:0] SYN_MASK_S2 = 16'h6666;
  localparam logic [15:0] SYN_MASK_S4 = 16'h7878;
  localparam logic [15:0] SYN_MASK_S8 = 16'h7F80;

  localparam int DATA_W = 11;
  localparam int CODE_W = 16;

  typedef enum logic [1:0] {
    CLS_CLEAN = 2'd0,
    CLS_SEC   = 2'd1,
    CLS_DED   = 2'd2
  } ham_cls_e;

  function automatic logic [DATA_W-1:0] ham_extract(input logic [CODE_W-1:0] c);
    return {c[14:8], c[6:4], c[2]};
  endfunction

endpackage

// File: rtl/ham_16_11_syn.sv
// Combinational syndrome, overall parity, classification and single-bit correction.
// Kept standalone so the memory scrubber can reuse the same decode function.
module ham_16_11_syn
  import ham_pkg::*;
#(
  parameter bit CORRECT_EN = 1'b1
) (
  input  logic [CODE_W-1:0] i_code,
  output logic [DATA_W-1:0] o_data,
  output ham_cls_e          o_cls
);

  logic [3:0]        w_syn;
  logic              w_par;
  logic [CODE_W-1:0] w_fixed;

  always_comb begin
    w_syn   = {^(i_code & SYN_MASK_S8), ^(i_code & SYN_MASK_S4),
               ^(i_code & SYN_MASK_S2), ^(i_code & SYN_MASK_S1)};
    w_par   = ^i_code;
    w_fixed = i_code;
    o_cls   = CLS_CLEAN;

    // Overall parity odd means a single error; a non-zero syndrome points at the bit
    if (w_par) begin
      o_cls = CLS_SEC;
      if (CORRECT_EN && (w_syn != 4'd0))
        w_fixed = i_code ^ (16'd1 << (w_syn - 4'd1));
    end else if (w_syn != 4'd0) begin
      o_cls = CLS_DED;
    end

    o_data = ham_extract(w_fixed);
  end

endmodule

// File: rtl/ham_16_11_dec_pipe.sv
// Two-stage elastic SECDED decoder for Hamming (16,11) codewords with
// saturating SEC/DED event counters and a sticky DED flag.
module ham_16_11_dec_pipe
  import ham_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter bit CORRECT_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [CODE_W-1:0] code_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic              sec_o,
  output logic              ded_o,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  sec_cnt_o,
  output logic [CNT_W-1:0]  ded_cnt_o,
  output logic              ded_sticky_o
);

  logic              r_s1_valid;
  logic [CODE_W-1:0] r_s1_code;
  logic              r_s2_valid;
  logic [DATA_W-1:0] r_s2_data;
  logic              r_s2_sec;
  logic              r_s2_ded;
  logic [CNT_W-1:0]  r_sec_cnt;
  logic [CNT_W-1:0]  r_ded_cnt;
  logic              r_ded_sticky;

  logic              w_s1_adv;
  logic              w_s2_adv;
  logic              w_out_hs;
  logic [DATA_W-1:0] w_dec_data;
  ham_cls_e          w_dec_cls;

  assign w_s2_adv = !r_s2_valid || ready_i;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign w_out_hs = r_s2_valid && ready_i;

  ham_16_11_syn #(
    .CORRECT_EN (CORRECT_EN)
  ) u_syn (
    .i_code (r_s1_code),
    .o_data (w_dec_data),
    .o_cls  (w_dec_cls)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s1_valid <= 1'b0;
      r_s1_code  <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= valid_i;
      if (valid_i)
        r_s1_code <= code_i;
    end
  end

  // S2 only captures when S1 holds a word, so outputs stay frozen while stalled
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_sec   <= 1'b0;
      r_s2_ded   <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_dec_data;
        r_s2_sec  <= (w_dec_cls == CLS_SEC);
        r_s2_ded  <= (w_dec_cls == CLS_DED);
      end
    end
  end

  // Clear takes priority, so an event coinciding with the clear is dropped
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sec_cnt    <= '0;
      r_ded_cnt    <= '0;
      r_ded_sticky <= 1'b0;
    end else if (cnt_clr_i) begin
      r_sec_cnt    <= '0;
      r_ded_cnt    <= '0;
      r_ded_sticky <= 1'b0;
    end else if (w_out_hs) begin
      if (r_s2_sec && (r_sec_cnt != {CNT_W{1'b1}}))
        r_sec_cnt <= r_sec_cnt + 1'b1;
      if (r_s2_ded && (r_ded_cnt != {CNT_W{1'b1}}))
        r_ded_cnt <= r_ded_cnt + 1'b1;
      if (r_s2_ded)
        r_ded_sticky <= 1'b1;
    end
  end

  assign ready_o      = w_s1_adv;
  assign valid_o      = r_s2_valid;
  assign data_o       = r_s2_data;
  assign sec_o        = r_s2_sec;
  assign ded_o        = r_s2_ded;
  assign sec_cnt_o    = r_sec_cnt;
  assign ded_cnt_o    = r_ded_cnt;
  assign ded_sticky_o = r_ded_sticky;

endmodule
